// File: rtl/queue_writer_module.sv
// Credit-tracked producer endpoint driving wr/entry_1 into queue_module.
// Optional tokens_written counter enabled by QUEUE_WRITER_STATS_EN.
module queue_writer_module #(
  parameter int BITS_NUMBER = 16,
  parameter int FIFO_ELEMENTS = 5,
  parameter int NUMBER_OF_PRECHARGE_DATA = 4,
  localparam int OCC_W = $clog2(FIFO_ELEMENTS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BITS_NUMBER-1:0] in_data,
  output logic                   in_ready,
  input  logic                   rd_seen,
`ifdef QUEUE_WRITER_STATS_EN
  output logic [31:0]            tokens_written,
`endif
  output logic                   wr,
  output logic [BITS_NUMBER-1:0] entry_1,
  output logic [OCC_W-1:0]       occupancy,
  output logic                   full
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_ELEMENTS);
  localparam logic [OCC_W-1:0] OCC_PRE = OCC_W'(NUMBER_OF_PRECHARGE_DATA);

  if (NUMBER_OF_PRECHARGE_DATA > FIFO_ELEMENTS) begin : g_bad_pre
    $error("NUMBER_OF_PRECHARGE_DATA exceeds FIFO_ELEMENTS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BITS_NUMBER-1:0] hold_q, hold_d;
  logic [BITS_NUMBER-1:0] entry_q, entry_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   wr_q, wr_d;
  logic                   inc, dec;

  assign full      = (occ_q == OCC_MAX);
  assign occupancy = occ_q;
  assign wr        = wr_q;
  assign entry_1   = entry_q;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    entry_d  = entry_q;
    wr_d     = 1'b0;
    inc      = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // space check sees only the registered count
        if (!full) begin
          wr_d    = 1'b1;
          entry_d = hold_q;
          inc     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset) in_ready = 1'b0;
  end

  always_comb begin
    dec   = rd_seen && (occ_q != '0);
    occ_d = occ_q;
    if (inc && !dec) occ_d = occ_q + 1'b1;
    else if (dec && !inc) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      entry_q <= '0;
      occ_q   <= OCC_PRE;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      entry_q <= entry_d;
      occ_q   <= occ_d;
      wr_q    <= wr_d;
    end
  end

`ifdef QUEUE_WRITER_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_q && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tokens_written = cnt_q;
`endif

endmodule

// File: tb/tb_queue_writer_module.sv
// Randomized and directed bench for queue_writer_module against a token-level model.
// Build with QUEUE_WRITER_STATS_EN to also check tokens_written.
module tb_queue_writer_module;

  localparam int MAXC = 5;
  localparam int PRE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        rd_seen;
  logic        wr;
  logic [15:0] entry_1;
  logic [2:0]  occupancy;
  logic        full;
`ifdef QUEUE_WRITER_STATS_EN
  logic [31:0] tokens_written;
`endif

  queue_writer_module dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .rd_seen(rd_seen),
`ifdef QUEUE_WRITER_STATS_EN
    .tokens_written(tokens_written),
`endif
    .wr(wr),
    .entry_1(entry_1),
    .occupancy(occupancy),
    .full(full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // token-level model: optional pending token, write pulse, credit count
  bit          m_hold = 1'b0;
  logic [15:0] m_tok = '0;
  bit          m_wr = 1'b0;
  logic [15:0] m_entry = '0;
  int          m_occ = PRE;
  longint      m_cnt = 0;
  bit          saw_beef;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit v, input logic [15:0] d,
                            input bit rd, input bit rst);
    bit issue;
    bit accept;
    if (!rst) begin
      m_hold = 1'b0;
      m_wr = 1'b0;
      m_entry = '0;
      m_occ = PRE;
      m_cnt = 0;
      return;
    end
    if (m_wr && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    issue = m_hold && (m_occ < MAXC);
    accept = !m_hold && v;
    if (issue) m_occ++;
    if (rd && m_occ - int'(issue) > 0) m_occ--;
    m_wr = issue;
    if (issue) begin
      m_entry = m_tok;
      m_hold = 1'b0;
    end
    if (accept) begin
      m_hold = 1'b1;
      m_tok = d;
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d,
                      input bit rd, input bit rst);
    in_valid = v;
    in_data = d;
    rd_seen = rd;
    reset = rst;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, rst && !m_hold});
    model_edge(v, d, rd, rst);
    @(posedge clk);
    #1;
    check("wr", {31'd0, wr}, {31'd0, m_wr});
    check("entry_1", {16'd0, entry_1}, {16'd0, m_entry});
    check("occupancy", {29'd0, occupancy}, 32'(m_occ));
    check("full", {31'd0, full}, {31'd0, m_occ == MAXC});
`ifdef QUEUE_WRITER_STATS_EN
    check("tokens_written", tokens_written, m_cnt[31:0]);
`endif
    if (wr && entry_1 == 16'hBEEF) saw_beef = 1'b1;
  endtask

  initial begin
    in_valid = 1'b0;
    in_data = '0;
    rd_seen = 1'b0;
    reset = 1'b0;
    saw_beef = 1'b0;

    // reset
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_occ", {29'd0, occupancy}, 32'd4);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_entry", {16'd0, entry_1}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);

    // single token, latency 2 edges
    step(1, 16'hA5A5, 0, 1);
    check("lat_wr0", {31'd0, wr}, 32'd0);
    step(0, 0, 0, 1);
    check("lat_wr1", {31'd0, wr}, 32'd1);
    check("lat_entry", {16'd0, entry_1}, 32'hA5A5);
    check("lat_occ", {29'd0, occupancy}, 32'd5);
    check("lat_full", {31'd0, full}, 32'd1);
    step(0, 0, 0, 1);
    check("lat_wr_drop", {31'd0, wr}, 32'd0);
    check("entry_hold", {16'd0, entry_1}, 32'hA5A5);

    // full stall
    step(1, 16'h0001, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    step(0, 0, 1, 1);
    check("stall_occ4", {29'd0, occupancy}, 32'd4);
    check("stall_wr0", {31'd0, wr}, 32'd0);
    step(0, 0, 0, 1);
    check("stall_wr", {31'd0, wr}, 32'd1);
    check("stall_entry", {16'd0, entry_1}, 32'h0001);
    check("stall_occ5", {29'd0, occupancy}, 32'd5);

    // inc and dec on the same edge
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 16'h1234, 0, 1);
    step(0, 0, 1, 1);
    check("both_occ", {29'd0, occupancy}, 32'd3);
    check("both_wr", {31'd0, wr}, 32'd1);
    step(0, 0, 0, 1);
    check("both_wr_once", {31'd0, wr}, 32'd0);

    // drain with underflow guard
    step(1, 16'h5555, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("drain_start", {29'd0, occupancy}, 32'd4);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1);
      check("drain_occ", {29'd0, occupancy}, 32'(i < 4 ? 3 - i : 0));
    end

    // reset while holding a token
    step(1, 16'hBEEF, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    check("beef_never", {31'd0, saw_beef}, 32'd0);
    check("beef_occ", {29'd0, occupancy}, 32'd4);
`ifdef QUEUE_WRITER_STATS_EN
    check("stats_rst", tokens_written, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'(i), 0, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
    end
    check("stats_3", tokens_written, 32'd3);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) != 0), 16'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
